// File: rtl/cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// cpu_bus_arbiter: joins the instruction-side and data-side sram-like ports
// onto one shared master port, keeping one transaction outstanding at a time.
// Optional feature: define BUS_ARB_RR_EN for alternating priority under contention.
// Rev 1.0
// ============================================================================
module cpu_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic              proto_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;      // 1 = data side owns the bus
    logic       proto_err_q, proto_err_d;
    logic       any_req, pick_data, cur_data, grant, drive;

`ifdef BUS_ARB_RR_EN
    logic       last_owner_q, last_owner_d;

    assign pick_data = data_req & (~inst_req | ~last_owner_q);
`else
    assign pick_data = data_req;
`endif

    assign any_req  = inst_req | data_req;
    assign grant    = (state_q == S_IDLE) & any_req;
    assign cur_data = (state_q == S_IDLE) ? pick_data : owner_q;
    assign drive    = grant | (state_q == S_ADDR);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        proto_err_d = proto_err_q | (bus_data_ok & (state_q != S_WAIT));
`ifdef BUS_ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d = pick_data;
`ifdef BUS_ARB_RR_EN
                    last_owner_d = pick_data;
`endif
                    state_d = bus_addr_ok ? S_WAIT : S_ADDR;
                end
            end
            S_ADDR:  if (bus_addr_ok) state_d = S_WAIT;
            S_WAIT:  if (bus_data_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            proto_err_q <= 1'b0;
`ifdef BUS_ARB_RR_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            proto_err_q <= proto_err_d;
`ifdef BUS_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    // Every output is forced low while reset is held, whatever the bus does.
    always_comb begin
        bus_req      = 1'b0;
        bus_wr       = 1'b0;
        bus_size     = 2'd0;
        bus_addr     = '0;
        bus_wdata    = '0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = '0;
        data_rdata   = '0;
        busy         = 1'b0;
        proto_err    = 1'b0;
        if (rst) begin
            if (drive) begin
                bus_req      = cur_data ? data_req   : inst_req;
                bus_wr       = cur_data ? data_wr    : inst_wr;
                bus_size     = cur_data ? data_size  : inst_size;
                bus_addr     = cur_data ? data_addr  : inst_addr;
                bus_wdata    = cur_data ? data_wdata : inst_wdata;
                inst_addr_ok = bus_addr_ok & ~cur_data;
                data_addr_ok = bus_addr_ok & cur_data;
            end
            if (state_q == S_WAIT) begin
                inst_data_ok = bus_data_ok & ~owner_q;
                data_data_ok = bus_data_ok & owner_q;
            end
            inst_rdata = bus_rdata;
            data_rdata = bus_rdata;
            busy       = (state_q != S_IDLE) | grant;
            proto_err  = proto_err_q;
        end
    end

endmodule
`default_nettype wire
